cim_mac_seq: RTL and testbench
==============================

CIM_MAC_SEQ -- requirements
Module: cim_mac_seq

Interface
REQ-001 Parameter ACC_W, default 32, accumulator and result width.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mac_start  input  1  level job request from cim_controller, held high until mac_done.
REQ-005 mac_done  output  1  one-cycle job-complete pulse to cim_controller.
REQ-006 dim_m, dim_n, dim_k  input  32 each  job dimensions; only bits [15:0] used.
REQ-007 sparse_enable  input  1  enable activation-sparsity skipping.
REQ-008 sparse_threshold  input  8  unsigned skip threshold.
REQ-009 op_valid / op_ready  input / output  1 / 1  operand-stream handshake.
REQ-010 op_act, op_wt  input  8 each  signed activation and weight.
REQ-011 res_valid / res_ready  output / input  1 / 1  result-stream handshake.
REQ-012 res_data  output  ACC_W  signed dot-product result.
REQ-013 sparse_total_ops, sparse_skipped_ops  output  16 each  per-job counters.
REQ-014 sparse_ratio  output  8  skipped*100/total, 0-100.

Function
REQ-015 States SHALL be IDLE, RUN, OUTPUT, RATIO, DONE, RELEASE.
REQ-016 IDLE: on mac_start=1, the block SHALL latch the dims and sparse inputs, clear acc and all three stats, and enter RUN; if any latched dim is 0, it SHALL enter DONE instead.
REQ-017 op_ready SHALL be 1 only in RUN; each transfer (op_valid&op_ready) is one op.
REQ-018 Per op: product = op_act*op_wt (16-bit signed), sign-extended; acc SHALL be updated next cycle, with two's-complement wrap and no saturation.
REQ-019 Skip: if sparse_enable and |op_act| < sparse_threshold, the product SHALL be treated as 0 and skipped_ops incremented; the op is still consumed.
REQ-020 total_ops SHALL increment per op; both counters SHALL saturate at 16'hFFFF.
REQ-021 After the dim_k-th op of an output, the block SHALL enter OUTPUT with res_valid=1 and res_data=acc.
REQ-022 res_data SHALL stay stable until res_ready.
REQ-023 On the OUTPUT transfer, the block SHALL clear acc; if M*N outputs are done, it SHALL go to RATIO, otherwise to RUN.
REQ-024 RATIO SHALL compute floor(skipped*100/total) by iterative subtraction in at most 101 cycles.
REQ-025 RATIO SHALL produce ratio 0 when total=0, then enter DONE.
REQ-026 DONE SHALL assert mac_done for exactly one cycle, then enter RELEASE.
REQ-027 RELEASE SHALL wait for mac_start=0, then enter IDLE; there SHALL be no retrigger while mac_start stays high.
REQ-028 Abort: mac_start=0 in RUN, OUTPUT or RATIO SHALL return the block to IDLE next cycle with res_valid=0 and no mac_done; stats SHALL hold their last values.
REQ-029 Stats SHALL remain readable and stable from DONE until the next job start.

Reset
REQ-030 On rst_n=0, state=IDLE and every output SHALL be 0: mac_done, op_ready, res_valid, res_data, all stats.
REQ-031 Reset mid-job SHALL discard the job with no mac_done after release.

Configuration
REQ-032 CIM_MAC_SEQ_SPARSE_EN defined: skipping, skipped_ops and RATIO behave as REQ-019 and REQ-024.
REQ-033 CIM_MAC_SEQ_SPARSE_EN undefined: sparse_enable and sparse_threshold SHALL be ignored, and skipped_ops and ratio SHALL stay 0.
REQ-034 CIM_MAC_SEQ_SPARSE_EN undefined: RATIO SHALL be bypassed, OUTPUT going directly to DONE.

Verification
REQ-035 M=N=1, K=4, act={1,2,3,4}, wt={2,2,2,2}, sparse off -> res_data=20, total=4, skipped=0, ratio=0, one mac_done pulse.
REQ-036 Same ops, sparse on, threshold=3 -> res_data=14, skipped=2, ratio=50.
REQ-037 M=2, N=1, K=2, res_ready held low 5 cycles -> res_data stable, op_ready=0 throughout, then second result follows.
REQ-038 dim_k=0 -> mac_done within 2 cycles of mac_start, no res_valid, total=0, ratio=0.
REQ-039 K=3 with acts {-128,-128,-128} and wts {-128,-128,-128}, ACC_W=32 -> res_data=49152; mac_start dropped mid-job -> IDLE, no mac_done.
REQ-040 rst_n pulsed low during RUN -> all outputs 0 immediately; next job correct.

Source files
------------

// File: rtl/cim_mac_seq.sv
// Sequenced signed 8x8 MAC engine with a level start / pulse done job handshake.
// Define CIM_MAC_SEQ_SPARSE_EN to enable activation-sparsity skipping and the skip-ratio stage.
module cim_mac_seq #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mac_start,
  output logic             mac_done,
  input  logic [31:0]      dim_m,
  input  logic [31:0]      dim_n,
  input  logic [31:0]      dim_k,
  input  logic             sparse_enable,
  input  logic [7:0]       sparse_threshold,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_act,
  input  logic [7:0]       op_wt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [15:0]      sparse_total_ops,
  output logic [15:0]      sparse_skipped_ops,
  output logic [7:0]       sparse_ratio
);

  typedef enum logic [2:0] {StIdle, StRun, StOutput, StRatio, StDone, StRelease} state_e;

  state_e            state_q, state_d;
  logic [15:0]       m_q, n_q, k_q, k_cnt_q, total_q;
  logic [31:0]       out_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic signed [15:0] prod;
  logic              start_job, op_fire, out_fire, last_op, last_out, skip;
  logic              unused;

  assign unused   = ^{dim_m[31:16], dim_n[31:16], dim_k[31:16]};
  assign prod     = $signed(op_act) * $signed(op_wt);
  assign op_fire  = (state_q == StRun) && op_valid;
  assign last_op  = (k_cnt_q + 16'd1) == k_q;
  assign last_out = (out_cnt_q + 32'd1) == (32'(m_q) * 32'(n_q));

  assign mac_done         = (state_q == StDone);
  assign op_ready         = (state_q == StRun);
  assign res_valid        = (state_q == StOutput);
  assign res_data         = acc_q;
  assign sparse_total_ops = total_q;

`ifdef CIM_MAC_SEQ_SPARSE_EN
  logic        sp_en_q, ratio_done, ratio_step;
  logic [7:0]  thr_q, ratio_q;
  logic [15:0] skipped_q;
  logic [22:0] rem_q;
  logic [8:0]  act_mag;

  // 9 bits so that |-128| is representable
  assign act_mag    = op_act[7] ? (9'd0 - {1'b1, op_act}) : {1'b0, op_act};
  assign skip       = sp_en_q && (act_mag < {1'b0, thr_q});
  assign ratio_step = rem_q >= 23'(total_q);
  assign ratio_done = (total_q == 16'd0) || !ratio_step;

  assign sparse_skipped_ops = skipped_q;
  assign sparse_ratio       = ratio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_en_q   <= 1'b0;
      thr_q     <= 8'd0;
      skipped_q <= 16'd0;
      rem_q     <= 23'd0;
      ratio_q   <= 8'd0;
    end else if (start_job) begin
      sp_en_q   <= sparse_enable;
      thr_q     <= sparse_threshold;
      skipped_q <= 16'd0;
      ratio_q   <= 8'd0;
    end else begin
      if (op_fire && skip && (skipped_q != 16'hFFFF)) skipped_q <= skipped_q + 16'd1;
      if (out_fire && last_out) rem_q <= 23'(skipped_q) * 23'd100;
      // Quotient by repeated subtraction; skipped <= total bounds it at 100 steps
      if ((state_q == StRatio) && mac_start && !ratio_done) begin
        rem_q   <= rem_q - 23'(total_q);
        ratio_q <= ratio_q + 8'd1;
      end
    end
  end
`else
  logic unused_sparse;

  assign unused_sparse      = ^{sparse_enable, sparse_threshold};
  assign skip               = 1'b0;
  assign sparse_skipped_ops = 16'd0;
  assign sparse_ratio       = 8'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_job = 1'b0;
    out_fire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mac_start) begin
          start_job = 1'b1;
          if ((dim_m[15:0] == 16'd0) || (dim_n[15:0] == 16'd0) || (dim_k[15:0] == 16'd0)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!mac_start)             state_d = StIdle;
        else if (op_fire && last_op) state_d = StOutput;
      end
      StOutput: begin
        if (!mac_start) begin
          state_d = StIdle;
        end else if (res_ready) begin
          out_fire = 1'b1;
`ifdef CIM_MAC_SEQ_SPARSE_EN
          state_d  = last_out ? StRatio : StRun;
`else
          state_d  = last_out ? StDone : StRun;
`endif
        end
      end
`ifdef CIM_MAC_SEQ_SPARSE_EN
      StRatio: begin
        if (!mac_start)      state_d = StIdle;
        else if (ratio_done) state_d = StDone;
      end
`endif
      StDone:    state_d = StRelease;
      StRelease: if (!mac_start) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= 16'd0;
      n_q       <= 16'd0;
      k_q       <= 16'd0;
      k_cnt_q   <= 16'd0;
      out_cnt_q <= 32'd0;
      acc_q     <= '0;
      total_q   <= 16'd0;
    end else if (start_job) begin
      m_q       <= dim_m[15:0];
      n_q       <= dim_n[15:0];
      k_q       <= dim_k[15:0];
      k_cnt_q   <= 16'd0;
      out_cnt_q <= 32'd0;
      acc_q     <= '0;
      total_q   <= 16'd0;
    end else begin
      if (op_fire) begin
        if (!skip) acc_q <= acc_q + ACC_W'(prod);
        if (total_q != 16'hFFFF) total_q <= total_q + 16'd1;
        k_cnt_q <= last_op ? 16'd0 : k_cnt_q + 16'd1;
      end
      if (out_fire) begin
        acc_q     <= '0;
        out_cnt_q <= out_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cim_mac_seq.sv
// Scoreboard bench for cim_mac_seq; expectations follow CIM_MAC_SEQ_SPARSE_EN when defined.
module tb_cim_mac_seq;

`ifdef CIM_MAC_SEQ_SPARSE_EN
  localparam bit SparseBuild = 1'b1;
`else
  localparam bit SparseBuild = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mac_start = 1'b0;
  logic        mac_done;
  logic [31:0] dim_m = '0, dim_n = '0, dim_k = '0;
  logic        sparse_enable = 1'b0;
  logic [7:0]  sparse_threshold = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_act = '0, op_wt = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [15:0] sparse_total_ops, sparse_skipped_ops;
  logic [7:0]  sparse_ratio;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_res = 0;
  int          act_tab[$];
  int          wt_tab[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cim_mac_seq #(.ACC_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mac_start          (mac_start),
    .mac_done           (mac_done),
    .dim_m              (dim_m),
    .dim_n              (dim_n),
    .dim_k              (dim_k),
    .sparse_enable      (sparse_enable),
    .sparse_threshold   (sparse_threshold),
    .op_valid           (op_valid),
    .op_ready           (op_ready),
    .op_act             (op_act),
    .op_wt              (op_wt),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .sparse_total_ops   (sparse_total_ops),
    .sparse_skipped_ops (sparse_skipped_ops),
    .sparse_ratio       (sparse_ratio)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Scoreboard pop on every result transfer
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      n_res++;
      if (exp_q.size() == 0) check_eq("res_extra", 32'(exp_q.size()), 32'd1);
      else                   check_eq("res_data", res_data, exp_q.pop_front());
    end
  end

  task automatic run_job(input int m, input int n, input int k, input int sp, input int thr,
                         input int stall);
    int nout, nops, idx, done_cnt, done_at, extra, stall_seen, res_base;
    int exp_tot, exp_sk, exp_ratio, a, w, mag;
    logic [31:0] acc;
    nout = (m == 0 || n == 0 || k == 0) ? 0 : m * n;
    nops = nout * k;
    exp_tot = 0;
    exp_sk = 0;
    for (int o = 0; o < nout; o++) begin
      acc = '0;
      for (int j = 0; j < k; j++) begin
        a = act_tab[o * k + j];
        w = wt_tab[o * k + j];
        mag = (a < 0) ? -a : a;
        exp_tot++;
        if (SparseBuild && sp != 0 && mag < thr) exp_sk++;
        else acc = acc + 32'(a * w);
      end
      exp_q.push_back(acc);
    end
    exp_ratio = (exp_tot == 0) ? 0 : (exp_sk * 100) / exp_tot;
    res_base = n_res;
    idx = 0;
    stall_seen = 0;
    done_cnt = 0;
    done_at = 0;
    @(posedge clk); #1;
    dim_m = 32'(m);
    dim_n = 32'(n);
    dim_k = 32'(k);
    sparse_enable = sp[0];
    sparse_threshold = 8'(thr);
    res_ready = (stall == 0);
    mac_start = 1'b1;
    op_valid = (nops > 0);
    if (nops > 0) begin
      op_act = 8'(act_tab[0]);
      op_wt = 8'(wt_tab[0]);
    end
    for (int cyc = 1; cyc <= 3000 && done_cnt == 0; cyc++) begin
      @(negedge clk);
      if (mac_done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (op_valid && op_ready) idx++;
      if (res_valid && !res_ready) begin
        check_eq("stall_data", res_data, exp_q[0]);
        check_eq("stall_op_ready", 32'(op_ready), 32'd0);
        stall_seen++;
      end
      @(posedge clk); #1;
      res_ready = (stall_seen >= stall);
      op_valid = (idx < nops) && ($urandom_range(3) != 0);
      if (idx < nops) begin
        op_act = 8'(act_tab[idx]);
        op_wt = 8'(wt_tab[idx]);
      end
    end
    check_eq("done_seen", 32'(done_cnt), 32'd1);
    if (nout == 0) check_eq("done_latency", 32'(done_at >= 1 && done_at <= 2), 32'd1);
    check_eq("total_ops", 32'(sparse_total_ops), 32'(exp_tot));
    check_eq("skipped_ops", 32'(sparse_skipped_ops), 32'(exp_sk));
    check_eq("ratio", 32'(sparse_ratio), 32'(exp_ratio));
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      extra += int'(mac_done);
      @(posedge clk); #1;
    end
    check_eq("no_retrigger", 32'(extra), 32'd0);
    mac_start = 1'b0;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("res_count", 32'(n_res - res_base), 32'(nout));
    check_eq("stats_hold", {16'(sparse_total_ops), 8'(sparse_ratio), 8'(sparse_skipped_ops)},
             {16'(exp_tot), 8'(exp_ratio), 8'(exp_sk)});
  endtask

  initial begin
    int idx, cnt, rv;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check_eq("reset_ctl", 32'({mac_done, op_ready, res_valid}), 32'd0);
    check_eq("reset_res_data", res_data, 32'd0);
    check_eq("reset_stats", {sparse_total_ops, sparse_skipped_ops}, 32'd0);
    check_eq("reset_ratio", 32'(sparse_ratio), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    act_tab = '{1, 2, 3, 4};
    wt_tab = '{2, 2, 2, 2};
    run_job(1, 1, 4, 0, 0, 0);
    run_job(1, 1, 4, 1, 3, 0);

    act_tab = '{3, -5, 7, 1};
    wt_tab = '{4, 6, -2, 9};
    run_job(2, 1, 2, 1, 4, 5);

    act_tab.delete();
    wt_tab.delete();
    run_job(1, 1, 0, 1, 3, 0);

    act_tab = '{-128, -128, -128};
    wt_tab = '{-128, -128, -128};
    run_job(1, 1, 3, 0, 0, 0);

    // Abort after three ops: no done, no result, stats frozen
    act_tab = '{5, 6, 7, 8, 1, 1, 1, 1};
    wt_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    @(posedge clk); #1;
    dim_m = 32'd1;
    dim_n = 32'd1;
    dim_k = 32'd8;
    sparse_enable = 1'b0;
    mac_start = 1'b1;
    op_valid = 1'b1;
    op_act = 8'(act_tab[0]);
    op_wt = 8'(wt_tab[0]);
    idx = 0;
    for (int cyc = 0; cyc < 50 && idx < 3; cyc++) begin
      @(negedge clk);
      if (op_valid && op_ready) idx++;
      @(posedge clk); #1;
      op_valid = (idx < 3);
      if (idx < 3) begin
        op_act = 8'(act_tab[idx]);
        op_wt = 8'(wt_tab[idx]);
      end
    end
    check_eq("abort_ops_taken", 32'(idx), 32'd3);
    mac_start = 1'b0;
    cnt = 0;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(mac_done);
      rv += int'(res_valid);
    end
    check_eq("abort_no_done", 32'(cnt), 32'd0);
    check_eq("abort_no_res", 32'(rv), 32'd0);
    check_eq("abort_op_ready", 32'(op_ready), 32'd0);
    check_eq("abort_total", 32'(sparse_total_ops), 32'd3);

    act_tab.delete();
    wt_tab.delete();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(255));
      act_tab.push_back(int'($signed(b)));
      b = 8'($urandom_range(255));
      wt_tab.push_back(int'($signed(b)));
    end
    run_job(2, 2, 3, 1, 40, 0);

    // Asynchronous reset in the middle of RUN
    act_tab = '{1, 2, 3, 4};
    wt_tab = '{2, 2, 2, 2};
    @(posedge clk); #1;
    dim_k = 32'd4;
    dim_m = 32'd1;
    dim_n = 32'd1;
    mac_start = 1'b1;
    op_valid = 1'b1;
    op_act = 8'(act_tab[0]);
    op_wt = 8'(wt_tab[0]);
    idx = 0;
    for (int cyc = 0; cyc < 50 && idx < 2; cyc++) begin
      @(negedge clk);
      if (op_valid && op_ready) idx++;
      @(posedge clk); #1;
      op_valid = (idx < 2);
      if (idx < 2) begin
        op_act = 8'(act_tab[idx]);
        op_wt = 8'(wt_tab[idx]);
      end
    end
    check_eq("mid_total_before_rst", 32'(sparse_total_ops), 32'd2);
    rst_n = 1'b0;
    mac_start = 1'b0;
    op_valid = 1'b0;
    #1;
    check_eq("mid_rst_ctl", 32'({mac_done, op_ready, res_valid}), 32'd0);
    check_eq("mid_rst_res_data", res_data, 32'd0);
    check_eq("mid_rst_stats", {sparse_total_ops, sparse_skipped_ops}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(mac_done);
    end
    check_eq("mid_rst_no_done", 32'(cnt), 32'd0);
    run_job(1, 1, 4, 1, 3, 0);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
